// File: rtl/int_ctrl.sv
// int_ctrl: four-source, single-level interrupt controller.
//
// Each irq_in rising edge latches into the pending register. The mask register
// does not affect latching; it only decides which pending sources can raise a
// request. The highest-priority enabled source (lowest index) is committed in
// IDLE. Its ID then stays frozen through the REQ -> TAKEN -> SERVICE handshake.
// Handlers do not nest.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   irq_in       interrupt sources, bit 0 is highest priority
//   mask_we      mask register write strobe
//   mask_wdata   new mask value (1 = source enabled)
//   int_take     CPU has redirected the PC to int_vec (valid in REQ)
//   epc_in       return PC, captured on int_take
//   iack         IACK instruction executing (valid in TAKEN)
//   rfe          RFE instruction executing (valid in SERVICE)
//   int_req      interrupt request to the CPU
//   int_vec      handler address for the committed source
//   int_id       committed source ID
//   epc_out      saved return PC
//   in_service   handler running (TAKEN or SERVICE)
//   pending      raw pending bits, not masked
//   mask         current mask register
module int_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  irq_in,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  input  logic        int_take,
  input  logic [31:0] epc_in,
  input  logic        iack,
  input  logic        rfe,
  output logic        int_req,
  output logic [31:0] int_vec,
  output logic [1:0]  int_id,
  output logic [31:0] epc_out,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic [3:0]  mask
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned XLEN  = 32;
  localparam logic [XLEN-1:0] VEC_BASE = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_TAKEN,
    ST_SERVICE
  } state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  irq_q;
  logic [N_SRC-1:0]  rise_c;
  logic [N_SRC-1:0]  enabled_c;
  logic [N_SRC-1:0]  clr_c;
  logic [N_SRC-1:0]  pending_d;
  logic [ID_W-1:0]   prio_id_c;
  logic [ID_W-1:0]   int_id_d;
  logic [XLEN-1:0]   epc_d;

  // Edge detect against the single sampled copy of irq_in.
  assign rise_c    = irq_in & ~irq_q;
  assign enabled_c = pending & mask;

  // Lowest set index of the enabled sources. The loop counts down so the
  // lowest index is assigned last and therefore wins.
  always_comb begin
    prio_id_c = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (enabled_c[i]) prio_id_c = ID_W'(i);
    end
  end

  // Next-state logic plus the values for the registered outputs.
  always_comb begin
    state_d  = state_q;
    int_id_d = int_id;
    epc_d    = epc_out;
    clr_c    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|enabled_c) begin
          state_d  = ST_REQ;
          int_id_d = prio_id_c;
        end
      end
      ST_REQ: begin
        if (int_take) begin
          state_d = ST_TAKEN;
          epc_d   = epc_in;
        end
      end
      ST_TAKEN: begin
        // iack has priority over a simultaneous rfe: only the acknowledge runs.
        if (iack) begin
          state_d = ST_SERVICE;
          clr_c   = N_SRC'(1) << int_id;
        end
      end
      ST_SERVICE: begin
        if (rfe) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new edge in the same cycle as the clear keeps the bit set.
    pending_d = (pending & ~clr_c) | rise_c;
  end

  // State and registered outputs. The outputs are computed from next-state
  // values so that each one lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      int_id     <= '0;
      epc_out    <= '0;
      int_req    <= 1'b0;
      in_service <= 1'b0;
      int_vec    <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_in;
      pending    <= pending_d;
      if (mask_we) mask <= mask_wdata;
      int_id     <= int_id_d;
      epc_out    <= epc_d;
      int_req    <= (state_d == ST_REQ);
      in_service <= (state_d == ST_TAKEN) || (state_d == ST_SERVICE);
      int_vec    <= VEC_BASE + (XLEN'(int_id_d) << 4);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl. Expected snapshots are queued as stimulus is
// applied, then popped and compared against the DUT outputs.
module tb_int_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_take;
  logic [31:0] epc_in;
  logic        iack;
  logic        rfe;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  int_id;
  logic [31:0] epc_out;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic [1:0]  id;
    logic        ins;
    logic [3:0]  pend;
    logic [31:0] epc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_take   (int_take),
    .epc_in     (epc_in),
    .iack       (iack),
    .rfe        (rfe),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .epc_out    (epc_out),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] vec_of(input logic [1:0] id);
    case (id)
      2'd0:    return 32'h0000_0100;
      2'd1:    return 32'h0000_0110;
      2'd2:    return 32'h0000_0120;
      default: return 32'h0000_0130;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic req, input logic [1:0] id,
                      input logic ins, input logic [3:0] pend, input logic [31:0] epc);
    exp_t e;
    e.req = req; e.id = id; e.ins = ins; e.pend = pend; e.epc = epc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Pops one expectation and compares it against the DUT outputs.
  task automatic compare();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".int_req"},    32'(int_req),    32'(e.req));
    chk({t, ".in_service"}, 32'(in_service), 32'(e.ins));
    chk({t, ".pending"},    32'(pending),    32'(e.pend));
    chk({t, ".epc_out"},    epc_out,         e.epc);
    if (e.req || e.ins) begin
      chk({t, ".int_id"},  32'(int_id), 32'(e.id));
      chk({t, ".int_vec"}, int_vec,     vec_of(e.id));
    end
  endtask

  task automatic expect_now(input string tag, input logic req, input logic [1:0] id,
                            input logic ins, input logic [3:0] pend, input logic [31:0] epc);
    push(tag, req, id, ins, pend, epc);
    compare();
  endtask

  // Advance one clock; inputs and checks happen 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    int_take = 1'b0; epc_in = '0; iack = 1'b0; rfe = 1'b0;

    // Reset values.
    tick(); tick();
    expect_now("reset", 1'b0, 2'd0, 1'b0, 4'h0, 32'h0);
    chk("reset.int_id", 32'(int_id), 32'h0);
    chk("reset.int_vec", int_vec, 32'h100);
    chk("reset.mask", 32'(mask), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic handshake on source 2.
    mask_we = 1'b1; mask_wdata = 4'hF; tick(); mask_we = 1'b0;
    chk("hs.mask", 32'(mask), 32'hF);
    irq_in = 4'b0100; tick(); irq_in = '0;
    expect_now("hs.pend", 1'b0, 2'd0, 1'b0, 4'b0100, 32'h0);
    tick();
    expect_now("hs.req", 1'b1, 2'd2, 1'b0, 4'b0100, 32'h0);
    int_take = 1'b1; epc_in = 32'h40; tick(); int_take = 1'b0;
    expect_now("hs.taken", 1'b0, 2'd2, 1'b1, 4'b0100, 32'h40);
    iack = 1'b1; tick(); iack = 1'b0;
    expect_now("hs.iack", 1'b0, 2'd2, 1'b1, 4'b0000, 32'h40);
    tick();
    expect_now("hs.service", 1'b0, 2'd2, 1'b1, 4'b0000, 32'h40);
    rfe = 1'b1; tick(); rfe = 1'b0;
    expect_now("hs.rfe", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h40);
    tick();
    expect_now("hs.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h40);

    // Priority: sources 3 and 1 together; ID frozen in REQ across mask writes.
    irq_in = 4'b1010; tick(); irq_in = '0;
    tick();
    expect_now("prio.first", 1'b1, 2'd1, 1'b0, 4'b1010, 32'h40);
    mask_we = 1'b1; mask_wdata = 4'h0; tick();
    expect_now("prio.frozen", 1'b1, 2'd1, 1'b0, 4'b1010, 32'h40);
    mask_wdata = 4'hF; tick(); mask_we = 1'b0;
    int_take = 1'b1; epc_in = 32'h80; tick(); int_take = 1'b0;
    iack = 1'b1; tick(); iack = 1'b0;
    expect_now("prio.iack", 1'b0, 2'd1, 1'b1, 4'b1000, 32'h80);
    rfe = 1'b1; tick(); rfe = 1'b0;
    expect_now("prio.rfe", 1'b0, 2'd0, 1'b0, 4'b1000, 32'h80);
    tick();
    expect_now("prio.second", 1'b1, 2'd3, 1'b0, 4'b1000, 32'h80);
    int_take = 1'b1; epc_in = 32'h84; tick(); int_take = 1'b0;
    iack = 1'b1; tick(); iack = 1'b0;
    rfe = 1'b1; tick(); rfe = 1'b0;
    expect_now("prio.done", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h84);

    // Masking: pending latches while masked; request follows the mask write.
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = '0;
    tick();
    expect_now("mask.blocked", 1'b0, 2'd0, 1'b0, 4'b0001, 32'h84);
    tick();
    expect_now("mask.still", 1'b0, 2'd0, 1'b0, 4'b0001, 32'h84);
    mask_we = 1'b1; mask_wdata = 4'hF; tick(); mask_we = 1'b0;
    expect_now("mask.write", 1'b0, 2'd0, 1'b0, 4'b0001, 32'h84);
    tick();
    expect_now("mask.req", 1'b1, 2'd0, 1'b0, 4'b0001, 32'h84);

    // Illegal sequencing.
    int_take = 1'b1; epc_in = 32'h200; tick(); int_take = 1'b0;
    expect_now("ill.taken", 1'b0, 2'd0, 1'b1, 4'b0001, 32'h200);
    rfe = 1'b1; tick(); rfe = 1'b0;
    expect_now("ill.rfe_taken", 1'b0, 2'd0, 1'b1, 4'b0001, 32'h200);
    iack = 1'b1; tick(); iack = 1'b0;
    expect_now("ill.iack", 1'b0, 2'd0, 1'b1, 4'b0000, 32'h200);
    int_take = 1'b1; epc_in = 32'hDEAD; tick(); int_take = 1'b0;
    expect_now("ill.take_svc", 1'b0, 2'd0, 1'b1, 4'b0000, 32'h200);
    rfe = 1'b1; tick(); rfe = 1'b0;
    iack = 1'b1; tick(); iack = 1'b0;
    expect_now("ill.iack_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h200);

    // Set beats clear, with a simultaneous iack+rfe in TAKEN.
    irq_in = 4'b0100; tick(); irq_in = '0;
    tick();
    expect_now("sbc.req", 1'b1, 2'd2, 1'b0, 4'b0100, 32'h200);
    int_take = 1'b1; epc_in = 32'h300; tick(); int_take = 1'b0;
    iack = 1'b1; rfe = 1'b1; irq_in = 4'b0100; tick();
    iack = 1'b0; rfe = 1'b0; irq_in = '0;
    expect_now("sbc.set_wins", 1'b0, 2'd2, 1'b1, 4'b0100, 32'h300);
    tick();
    expect_now("sbc.in_service", 1'b0, 2'd2, 1'b1, 4'b0100, 32'h300);
    rfe = 1'b1; tick(); rfe = 1'b0;
    expect_now("sbc.rfe", 1'b0, 2'd0, 1'b0, 4'b0100, 32'h300);
    tick();
    expect_now("sbc.rereq", 1'b1, 2'd2, 1'b0, 4'b0100, 32'h300);

    // Reset asserted asynchronously while in SERVICE with another edge pending.
    int_take = 1'b1; epc_in = 32'h400; tick(); int_take = 1'b0;
    iack = 1'b1; tick(); iack = 1'b0;
    irq_in = 4'b0010; tick(); irq_in = '0;
    expect_now("rst.pre", 1'b0, 2'd2, 1'b1, 4'b0010, 32'h400);
    #2 rst_n = 1'b0;
    #1;
    expect_now("rst.async", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
    chk("rst.async.int_id", 32'(int_id), 32'h0);
    chk("rst.async.int_vec", int_vec, 32'h100);
    chk("rst.async.mask", 32'(mask), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    expect_now("rst.after", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
